memory_sync_ram_ctrl: RTL and testbench



---
 rtl/memory_sync_ram_ctrl_if.sv | 43 ++++
 rtl/memory_sync_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_memory_sync_ram_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_sync_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// memory_sync_ram_ctrl_if
//   Request/response bundle between a memory requester (master) and
//   memory_sync_ram_ctrl (slave). AW/DW must match the controller's.
//
//   req    master->slave  access request, held until ready
//   we     master->slave  1 = write, 0 = read
//   be     master->slave  byte-lane write enables, be[i] covers din[8i+7:8i]
//   addr   master->slave  word address
//   din    master->slave  write data
//   clr    master->slave  full-array clear request (honoured only when idle)
//   ready  slave->master  an access can be accepted this cycle
//   busy   slave->master  clear engine running
//   rdata  slave->master  registered read data
//   rvalid slave->master  one-cycle pulse per completed read
// ----------------------------------------------------------------------------
interface memory_sync_ram_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    localparam int NB = DW / 8;

    logic          req;
    logic          we;
    logic [NB-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          clr;
    logic          ready;
    logic          busy;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (
        output req, we, be, addr, din, clr,
        input  ready, busy, rdata, rvalid
    );

    modport slave (
        input  req, we, be, addr, din, clr,
        output ready, busy, rdata, rvalid
    );
endinterface

// File: rtl/memory_sync_ram_ctrl.sv
// ----------------------------------------------------------------------------
// memory_sync_ram_ctrl
//   Single-port synchronous RAM (2**AW x DW) with request/ready handshake,
//   per-byte write enables, RD_LAT-cycle registered read (1 or 2) and a
//   clear engine that zeroes the whole array after reset and on clr.
//
//   clk  in   rising-edge clock
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of memory_sync_ram_ctrl_if (req/we/be/addr/din/clr in,
//        ready/busy/rdata/rvalid out)
// ----------------------------------------------------------------------------
module memory_sync_ram_ctrl #(
    parameter int    AW             = 9,
    parameter int    DW             = 16,
    parameter int    RD_LAT         = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    memory_sync_ram_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("memory_sync_ram_ctrl: RD_LAT must be 1 or 2");
    end
    if (DW % 8 != 0) begin : g_bad_dw
        $error("memory_sync_ram_ctrl: DW must be a multiple of 8");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t                  state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [DW-1:0]           mem [DEPTH];

    logic                    ready;
    logic                    acc;
    logic                    rd_acc;
    logic                    wr_acc;

    // Read pipeline: stage 1 captures the array word at the accepting edge,
    // stage RD_LAT drives rdata/rvalid.
    logic [RD_LAT:1]         vld_pipe_q;
    logic [RD_LAT:1][DW-1:0] dat_pipe_q;

    // Decoded from registered state only, so no input-to-output path.
    assign ready  = (state_q == S_IDLE);
    assign acc    = bus.req & ready;
    assign rd_acc = acc & ~bus.we;
    assign wr_acc = acc &  bus.we;

    assign bus.ready  = ready;
    assign bus.busy   = (state_q == S_CLEAR);
    assign bus.rdata  = dat_pipe_q[RD_LAT];
    assign bus.rvalid = vld_pipe_q[RD_LAT];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                // A request in the same cycle is still accepted; the clear
                // only takes over from the next cycle.
                if (bus.clr) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                // The pointer wraps to 0 naturally after DEPTH-1, so the
                // next clear starts from the bottom again.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = S_IDLE;
            end
            default: state_d = RST_STATE;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: not reset; the clear engine owns initialisation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.din[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q[1] <= 1'b0;
            dat_pipe_q[1] <= '0;
        end else begin
            vld_pipe_q[1] <= rd_acc;
            // Only loads on a read so rdata holds between reads.
            if (rd_acc) dat_pipe_q[1] <= mem[bus.addr];
        end
    end

    for (genvar k = 2; k <= RD_LAT; k++) begin : g_rd_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe_q[k] <= 1'b0;
                dat_pipe_q[k] <= '0;
            end else begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (vld_pipe_q[k-1]) dat_pipe_q[k] <= dat_pipe_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_memory_sync_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_memory_sync_ram_ctrl
//   Two controllers (RD_LAT=1 and RD_LAT=2) receive identical traffic and are
//   compared every cycle against a transaction-level model: a word array,
//   a clear countdown and a queue of pending read returns per latency.
// ----------------------------------------------------------------------------
module tb_memory_sync_ram_ctrl;
    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    memory_sync_ram_ctrl_if #(.AW(AW), .DW(DW)) ba ();
    memory_sync_ram_ctrl_if #(.AW(AW), .DW(DW)) bb ();

    assign bb.req  = ba.req;
    assign bb.we   = ba.we;
    assign bb.be   = ba.be;
    assign bb.addr = ba.addr;
    assign bb.din  = ba.din;
    assign bb.clr  = ba.clr;

    memory_sync_ram_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1), .CLEAR_ON_RESET(1), .INIT_FILE(""))
        u_dut_l1 (.clk(clk), .rst(rst), .bus(ba.slave));
    memory_sync_ram_ctrl #(.AW(AW), .DW(DW), .RD_LAT(2), .CLEAR_ON_RESET(1), .INIT_FILE(""))
        u_dut_l2 (.clk(clk), .rst(rst), .bus(bb.slave));

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    logic [15:0] mm [DEPTH];
    int          clear_left;
    int          cyc;
    rd_t         qa[$];
    rd_t         qb[$];
    logic [15:0] last_a, last_b;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        clear_left = DEPTH;
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [1:0] b,
                              input logic [8:0] a, input logic [15:0] d, input logic c);
        rd_t e;
        cyc++;
        if (clear_left == 0) begin
            if (r && w) begin
                for (int i = 0; i < 2; i++)
                    if (b[i]) mm[a][8*i +: 8] = d[8*i +: 8];
            end else if (r) begin
                e.data = mm[a];
                e.due  = cyc;
                qa.push_back(e);
                e.due  = cyc + 1;
                qb.push_back(e);
            end
            if (c) begin
                clear_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
            end
        end else begin
            clear_left--;
        end
    endtask

    task automatic check_outputs();
        logic ev_a, ev_b;
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ev_a = 1'b1; last_a = qa[0].data; void'(qa.pop_front());
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            ev_b = 1'b1; last_b = qb[0].data; void'(qb.pop_front());
        end
        chk("ready_l1",  32'(ba.ready),  32'(clear_left == 0));
        chk("busy_l1",   32'(ba.busy),   32'(clear_left != 0));
        chk("ready_l2",  32'(bb.ready),  32'(clear_left == 0));
        chk("busy_l2",   32'(bb.busy),   32'(clear_left != 0));
        chk("rvalid_l1", 32'(ba.rvalid), 32'(ev_a));
        chk("rdata_l1",  32'(ba.rdata),  32'(last_a));
        chk("rvalid_l2", 32'(bb.rvalid), 32'(ev_b));
        chk("rdata_l2",  32'(bb.rdata),  32'(last_b));
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance model.
    task automatic step(input logic r, input logic w, input logic [1:0] b,
                        input logic [8:0] a, input logic [15:0] d, input logic c);
        ba.req = r; ba.we = w; ba.be = b; ba.addr = a; ba.din = d; ba.clr = c;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(r, w, b, a, d, c);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, 9'd0, 16'h0, 1'b0);
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] b);
        step(1'b1, 1'b1, b, a, d, 1'b0);
    endtask

    task automatic rd(input logic [8:0] a);
        step(1'b1, 1'b0, 2'b00, a, 16'h0, 1'b0);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        int n;
        ba.req = 1'b0; ba.clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rvalid_l1", 32'(ba.rvalid), 32'd0);
        chk("rst_rdata_l1",  32'(ba.rdata),  32'd0);
        chk("rst_rvalid_l2", 32'(bb.rvalid), 32'd0);
        chk("rst_rdata_l2",  32'(bb.rdata),  32'd0);
        chk("rst_ready",     32'(ba.ready),  32'd0);
        chk("rst_busy",      32'(ba.busy),   32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n = 0;
        while (ba.ready !== 1'b1 && n < 1000) begin
            idle();
            n++;
        end
        chk("clear_cycles", 32'(n), 32'(DEPTH));
    endtask

    initial begin
        cyc = 0;
        ba.req = 1'b0; ba.we = 1'b0; ba.be = '0; ba.addr = '0; ba.din = '0; ba.clr = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Cleared array reads zero
        rd(9'd5);
        idle(); idle();

        // Write then read same address next cycle
        wr(9'd0, 16'hABCD, 2'b11);
        rd(9'd0);
        idle(); idle(); idle();

        // Byte lanes at the top address
        wr(9'd511, 16'h1234, 2'b11);
        wr(9'd511, 16'hFF00, 2'b10);
        rd(9'd511);
        wr(9'd511, 16'h5555, 2'b00);
        rd(9'd511);
        idle(); idle(); idle();

        // Streaming writes then streaming reads
        for (int i = 0; i < 10; i++) wr(9'(i), 16'(i), 2'b11);
        for (int i = 0; i < 10; i++) rd(9'(i));
        idle(); idle(); idle();

        // Random traffic over a small address window for frequent hits
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                 9'($urandom_range(0, 15)), 16'($urandom), 1'b0);
        idle(); idle(); idle();

        // Read in flight while clear starts returns pre-clear data;
        // a write held through the whole clear must be ignored.
        wr(9'd100, 16'h7777, 2'b11);
        step(1'b1, 1'b0, 2'b00, 9'd511, 16'h0, 1'b1);
        for (int i = 0; i < 1000 && clear_left != 0; i++)
            step(1'b1, 1'b1, 2'b11, 9'd100, 16'hFFFF, 1'b0);
        rd(9'd100);
        rd(9'd0);
        rd(9'd511);
        rd(9'd3);
        idle(); idle(); idle();

        // Reset with a read in flight: no rvalid pulse afterwards
        wr(9'd0, 16'hABCD, 2'b11);
        rd(9'd0);
        do_reset();
        rd(9'd0);
        idle(); idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
